// File: rtl/hack_memory_bus_if.sv
//-----------------------------------------------------------------------------
// hack_memory_bus_if
//   Bus bundle between the Hack CPU side and the data-memory stage.
//   It carries three groups of signals:
//     CPU data port : addressM[14:0], outM[15:0], writeM, inM[15:0]
//     Keyboard      : kbd_code[15:0], kbd_press, kbd_rel
//     Display FIFO  : disp_valid, disp_ready, disp_addr[SCR_AW-1:0],
//                     disp_data[15:0]
//   Modports
//     master : environment side (CPU, keyboard front end, display controller)
//     slave  : memory stage (hack_memory_bus)
//   Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

interface hack_memory_bus_if #(
  parameter int SCR_AW = 13
);
  logic [14:0]       addressM;
  logic [15:0]       outM;
  logic              writeM;
  logic [15:0]       inM;

  logic [15:0]       kbd_code;
  logic              kbd_press;
  logic              kbd_rel;

  logic              disp_valid;
  logic              disp_ready;
  logic [SCR_AW-1:0] disp_addr;
  logic [15:0]       disp_data;

  modport master (
    output addressM, outM, writeM, kbd_code, kbd_press, kbd_rel, disp_ready,
    input  inM, disp_valid, disp_addr, disp_data
  );

  modport slave (
    input  addressM, outM, writeM, kbd_code, kbd_press, kbd_rel, disp_ready,
    output inM, disp_valid, disp_addr, disp_data
  );
endinterface

`default_nettype wire

// File: rtl/hack_memory_bus.sv
//-----------------------------------------------------------------------------
// hack_memory_bus
//   Data-memory stage for the Hack CPU. Holds the data RAM, the screen shadow
//   RAM and the keyboard register, returns inM combinationally from addressM,
//   and queues every screen write into a FIFO feeding the display controller.
//
//   Ports
//     clk     in   clock; all writes commit on the rising edge
//     reset   in   asynchronous, active-low reset
//     bus     slave modport of hack_memory_bus_if (CPU, keyboard, display)
//     scr_ovf out  sticky flag: a screen write found the FIFO full
//                  (present only when HACK_SCR_OVF_EN is defined)
//
//   Address map (addressM)
//     0x0000-0x3FFF data RAM, 0x4000-0x5FFF screen RAM, 0x6000 keyboard,
//     0x6001-0x7FFF unmapped (reads 0, writes ignored).
//
//   Build option: define HACK_SCR_OVF_EN to add the scr_ovf output.
//   Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module hack_memory_bus #(
  parameter int RAM_AW     = 14,
  parameter int SCR_AW     = 13,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  hack_memory_bus_if.slave bus
`ifdef HACK_SCR_OVF_EN
  ,
  output logic             scr_ovf
`endif
);

  localparam int ENTRY_W = SCR_AW + 16;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic ram_sel;
  logic scr_sel;
  logic kbd_sel;

  always_comb begin
    ram_sel = (bus.addressM[14] == 1'b0);
    scr_sel = (bus.addressM[14:13] == 2'b10);
    kbd_sel = (bus.addressM == 15'h6000);
  end

  // ---------------------------------------------------------------------------
  // Storage arrays (never reset)
  // ---------------------------------------------------------------------------
  logic [15:0]        ram_mem  [0:(1<<RAM_AW)-1];
  logic [15:0]        scr_mem  [0:(1<<SCR_AW)-1];
  logic [ENTRY_W-1:0] fifo_mem [0:FIFO_DEPTH-1];

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [15:0]      kbd_q,    kbd_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q,    ovf_d;

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic push_ok;
  logic pop;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes a full ring from an empty one.
    fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    push_req   = bus.writeM && scr_sel;
    pop        = !fifo_empty && bus.disp_ready;
    // A simultaneous pop frees the slot the push lands in, so full is no
    // obstacle then; the head is read out before the edge overwrites it.
    push_ok    = push_req && (!fifo_full || pop);
  end

  always_comb begin
    kbd_d    = kbd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    // Press has priority over release when both strobes coincide.
    if (bus.kbd_press) begin
      kbd_d = bus.kbd_code;
    end else if (bus.kbd_rel) begin
      kbd_d = 16'h0000;
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbd_q    <= 16'h0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      kbd_q    <= kbd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Array writes. The screen RAM commits even when the FIFO drops the entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (bus.writeM && ram_sel) begin
      ram_mem[bus.addressM[RAM_AW-1:0]] <= bus.outM;
    end
  end

  always_ff @(posedge clk) begin
    if (push_req) begin
      scr_mem[bus.addressM[SCR_AW-1:0]] <= bus.outM;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {bus.addressM[SCR_AW-1:0], bus.outM};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.inM = 16'h0000;
    if (ram_sel) begin
      bus.inM = ram_mem[bus.addressM[RAM_AW-1:0]];
    end else if (scr_sel) begin
      bus.inM = scr_mem[bus.addressM[SCR_AW-1:0]];
    end else if (kbd_sel) begin
      bus.inM = kbd_q;
    end
  end

  // Head fields are forced to zero while empty so the outputs never expose a
  // stale or uninitialised slot.
  always_comb begin
    bus.disp_valid = !fifo_empty;
    {bus.disp_addr, bus.disp_data} = '0;
    if (!fifo_empty) begin
      {bus.disp_addr, bus.disp_data} = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
    end
  end

`ifdef HACK_SCR_OVF_EN
  assign scr_ovf = ovf_q;
`else
  // Drop tracking still exists internally but has no observer in this build.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

`default_nettype wire
